// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data, occupancy count,
// programmable almost-full/almost-empty thresholds and one-cycle
// overflow/underflow pulses. Every location is usable, so the count
// register runs from 0 to DEPTH and is one bit wider than the pointers.

module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int AF_LVL = (1 << ADDR_W) - 2,
    parameter int AE_LVL = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 1 << ADDR_W;

    // Thresholds pre-sized to the count width so the flag decodes compare
    // like-for-like vectors.
    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   AF_CNT    = (ADDR_W+1)'(AF_LVL);
    localparam logic [ADDR_W:0]   AE_CNT    = (ADDR_W+1)'(AE_LVL);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_ZERO  = '0;
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_ok;
    logic              rd_ok;

    // Status flags are pure decodes of the registered count, so they change
    // the cycle after the edge that moved the count.
    assign empty        = (count == CNT_ZERO);
    assign full         = (count == DEPTH_CNT);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    // Acceptance uses the pre-edge flags: a full FIFO refuses a write even if
    // a read frees a slot this cycle, and an empty FIFO never falls through.
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    // Storage array: not reset, and writes are held off while reset is high.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH because they are exactly ADDR_W bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Occupancy moves only when exactly one side is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Read data register: loads on an accepted read, otherwise holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
        end else if (rd_ok) begin
            dout <= mem[rd_ptr];
        end
    end

    // Error pulses: one cycle high after any edge that saw a request
    // against a full (write) or empty (read) FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
        end
    end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter: DATA_W, 8, data word width in bits (>=1).
REQ-002 Parameter: ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries, all usable (default 16).
REQ-003 Parameter: AF_LVL, DEPTH-2, almost_full asserts when count >= AF_LVL.
REQ-004 Parameter: AE_LVL, 2, almost_empty asserts when count <= AE_LVL.
REQ-005 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-006 Port: rst  input  1  reset, synchronous, active-high.
REQ-007 Port: din  input  DATA_W  write data.
REQ-008 Port: wr_en  input  1  write request.
REQ-009 Port: rd_en  input  1  read request.
REQ-010 Port: dout  output  DATA_W  registered read data.
REQ-011 Port: empty  output  1  high when count == 0.
REQ-012 Port: full  output  1  high when count == DEPTH.
REQ-013 Port: almost_full  output  1  count >= AF_LVL.
REQ-014 Port: almost_empty  output  1  count <= AE_LVL.
REQ-015 Port: count  output  ADDR_W+1  number of stored entries, 0..DEPTH.
REQ-016 Port: overflow  output  1  one-cycle pulse: write attempted while full.
REQ-017 Port: underflow  output  1  one-cycle pulse: read attempted while empty.

Function
REQ-018 Write accepted (wr_ok) iff wr_en && !full, evaluated on pre-edge state; on acceptance mem[wr_ptr] <= din, wr_ptr increments.
REQ-019 Read accepted (rd_ok) iff rd_en && !empty; on acceptance dout <= mem[rd_ptr], rd_ptr increments; latency 1 clock from accepted rd_en to dout valid.
REQ-020 dout holds its last value when no read is accepted, including reads rejected for empty.
REQ-021 Read and write are independent: both may be accepted in the same cycle; count unchanged in that case.
REQ-022 count: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither; never exceeds DEPTH or goes below 0.
REQ-023 When full, a write is rejected even if a read is accepted in the same cycle; count goes DEPTH -> DEPTH-1.
REQ-024 When empty, a read is rejected even if a write is accepted in the same cycle (no fall-through); count goes 0 -> 1, dout unchanged.
REQ-025 Pointers are ADDR_W bits and wrap from DEPTH-1 to 0 with no loss of data order.
REQ-026 empty, full, almost_full, almost_empty are decoded from the registered count (valid the cycle after the causing edge).
REQ-027 overflow registered high for exactly one cycle after an edge where wr_en && full; underflow likewise for rd_en && empty.
REQ-028 Memory contents are not reset; data is never read from an unwritten location because rd_ok requires !empty.
REQ-029 Parameter combinations with AF_LVL > DEPTH or AE_LVL >= DEPTH are illegal; behaviour is unspecified.

Reset
REQ-030 While rst is high at a clock edge: wr_ptr, rd_ptr, count, dout, overflow, underflow <= 0; wr_en/rd_en ignored.
REQ-031 Post-reset outputs: empty=1, full=0, almost_empty=1, almost_full=0, count=0, dout=0.
REQ-032 Reset mid-operation discards all stored entries; the first write after reset lands in entry 0 and is the next word read.

Verification
REQ-033 Reset, then write 0x01..0x10 (16 writes) -> full=1, count=16, almost_full high from count=14; 17th write -> overflow pulse 1 cycle, count stays 16.
REQ-034 From full, read 16 times -> dout = 0x01..0x10 in order, each 1 cycle after rd_en; empty=1 after last; extra read -> underflow pulse, dout stays 0x10.
REQ-035 Fill to 8, then 40 cycles of simultaneous wr_en/rd_en with incrementing data -> count stays 8, read order matches write order across pointer wrap.
REQ-036 Full plus simultaneous wr_en/rd_en -> read accepted, write rejected, overflow pulse, count 15; empty plus both -> write accepted, read rejected, underflow pulse, count 1.
REQ-037 Write 5 words, assert rst 1 cycle, write 0xAA, read -> dout=0xAA, count returns to 0, empty=1.
REQ-038 Re-run REQ-033/034 with DATA_W=32, ADDR_W=3 -> full at count=8, data 0xDEADBEEF preserved intact.
